tx_frame_arbiter: RTL

Frame-granular AXI-Stream arbiter that shares the single AXIS input of the 10G TX MAC between several frame sources, such as the host datapath, the pause-frame generator and the diagnostic frame source. A grant is held from the first beat to the `tlast` beat of a frame, so frames never interleave inside the MAC's store-and-forward FIFO. Port 0 optionally has strict priority, and the remaining ports are served round-robin. The output is a single registered stage that feeds the MAC's `in_slave_tx_*` ports directly.

---
 rtl/tx_mac_pkg.sv | 30 +++
 rtl/rr_priority_select.sv | 45 ++++
 rtl/tx_frame_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tx_mac_pkg.sv
// ----------------------------------------------------------------------------
// tx_mac_pkg: shared constants and types for the 10G TX MAC datapath. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tx_mac_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam int MIN_PAYLOAD_SIZE = 46;
  localparam int MAX_PAYLOAD_SIZE = 1500;
  localparam int IFG_SIZE         = 12;

endpackage

`default_nettype wire

// File: rtl/rr_priority_select.sv
// ----------------------------------------------------------------------------
// rr_priority_select: round-robin winner search with optional port-0 priority. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_priority_select
  import tx_mac_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_PORTS),
  parameter int PRIO_PORT0 = 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [ID_WIDTH-1:0]  ptr_i,
  output logic [ID_WIDTH-1:0]  winner_o,
  output logic                 valid_o
);

  logic [NUM_PORTS-1:0] req_masked;

  always_comb begin
    req_masked = req_i;
    if (PRIO_PORT0 != 0) req_masked[0] = 1'b0;
  end

  // Priority port short-circuits; otherwise first requester after ptr_i, with wrap.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    if ((PRIO_PORT0 != 0) && req_i[0]) begin
      winner_o = '0;
      valid_o  = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!valid_o && req_masked[(int'(ptr_i) + k) % NUM_PORTS]) begin
          winner_o = ID_WIDTH'((int'(ptr_i) + k) % NUM_PORTS);
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tx_frame_arbiter: frame-granular AXIS arbiter feeding the 10G TX MAC input. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tx_frame_arbiter
  import tx_mac_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int PRIO_PORT0 = 1,
  parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                            tx_clk,
  input  logic                            tx_rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [KEEP_WIDTH-1:0]           m_tkeep,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic                            busy
);

  logic [0:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  out_ready;
  logic                  accept;
  logic [ID_WIDTH-1:0]   win_id;
  logic                  win_valid;

  rr_priority_select #(
    .NUM_PORTS  (NUM_PORTS),
    .ID_WIDTH   (ID_WIDTH),
    .PRIO_PORT0 (PRIO_PORT0)
  ) u_select (
    .req_i    (s_tvalid),
    .ptr_i    (rr_ptr_q),
    .winner_o (win_id),
    .valid_o  (win_valid)
  );

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
      end
    end
  end

  // Ready is a function of registered state and m_tready only, never s_tvalid.
  assign out_ready = !tvalid_q || m_tready;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_tready[i] = (state_q == ST_PASS) && (grant_q == ID_WIDTH'(i)) && out_ready;
    end
  end

  assign accept = (state_q == ST_PASS) && sel_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d = win_id;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (accept && sel_last) begin
          state_d = ST_IDLE;
          // A priority port-0 frame must not disturb the round-robin rotation.
          if (!((PRIO_PORT0 != 0) && (grant_q == '0))) rr_ptr_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (accept) begin
      tdata_d  = sel_data;
      tkeep_d  = sel_keep;
      tlast_d  = sel_last;
      tvalid_d = 1'b1;
    end else if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= ID_WIDTH'(NUM_PORTS - 1);
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tkeep  = tkeep_q;
  assign m_tlast  = tlast_q;
  assign m_tvalid = tvalid_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == ST_PASS);

endmodule

`default_nettype wire
